// File: rtl/pop_timing_pkg.sv
// pop_timing_pkg: shared debounce state type and default timing constants
package pop_timing_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, REL_PEND} debounce_state_t;
  localparam int DEBOUNCE_STABLE_SAMPLES = 4;
  localparam int DEBOUNCE_REPEAT_DELAY = 2;
endpackage

// File: rtl/tick_edge_detect.sv
// tick_edge_detect: rising-edge strobe of a divider square wave; edge register resets high
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic strobe
);
  logic tick_q, tick_d;
  always_comb tick_d = tick;
  always_ff @(posedge clk) tick_q <= rst ? 1'b1 : tick_d;
  assign strobe = tick & ~tick_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: debounced level plus press/release strobes; auto-repeat under BUTTON_DEBOUNCER_AUTOREPEAT_EN
module button_debouncer
  import pop_timing_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEBOUNCE_STABLE_SAMPLES,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_DELAY = DEBOUNCE_REPEAT_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic sample_tick,
  input  logic repeat_tick,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  debounce_state_t state_q, state_d;
  logic press_q, press_d, release_q, release_d;
  logic btn_sync, sample_stb, disagree, flip, level_d, rep_fire;
  tick_edge_detect u_sample (
    .clk(clk),
    .rst(rst),
    .tick(sample_tick),
    .strobe(sample_stb)
  );
  assign btn_sync = sync_q[SYNC_STAGES-1];
  assign btn_level = state_q == PRESSED || state_q == REL_PEND;
  assign disagree = sample_stb && (btn_sync != btn_level);
  assign flip = disagree && (int'(cnt_q) + 1 >= STABLE_SAMPLES);
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d = disagree && !flip ? cnt_q + 1'b1 : sample_stb ? '0 : cnt_q;
    state_d = state_q;
    if (flip) state_d = btn_level ? RELEASED : PRESSED;
    else if (disagree) state_d = btn_level ? REL_PEND : PRESS_PEND;
    else if (sample_stb) state_d = btn_level ? PRESSED : RELEASED;
    level_d = state_d == PRESSED || state_d == REL_PEND;
    press_d = (level_d && !btn_level) || rep_fire;
    release_d = !level_d && btn_level;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      state_q <= RELEASED;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  end
  assign press_pulse = press_q;
  assign release_pulse = release_q;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic repeat_stb, hold;
  tick_edge_detect u_repeat (
    .clk(clk),
    .rst(rst),
    .tick(repeat_tick),
    .strobe(repeat_stb)
  );
  // only a press that stays pressed through this edge counts toward repeats
  assign hold = state_q == PRESSED && state_d == PRESSED;
  assign rep_fire = hold && repeat_stb && int'(rcnt_q) == REPEAT_DELAY;
  always_comb rcnt_d = !hold ? '0 : (repeat_stb && int'(rcnt_q) < REPEAT_DELAY) ? rcnt_q + 1'b1 : rcnt_q;
  always_ff @(posedge clk) rcnt_q <= rst ? '0 : rcnt_d;
`else
  logic unused_repeat;
  assign unused_repeat = repeat_tick ^ (REPEAT_DELAY > 0);
  assign rep_fire = 1'b0;
`endif
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw push-button input into a clean debounced level and single-cycle press/release strobes. It sits between the slow clock-pulse divider, whose debounce tick (256-cycle period at 2.5 MHz, about 100 µs) it consumes as a sample strobe, and the quad state machine, which it advances once per press. Optional auto-repeat uses the divider's fast pulse to emit repeated press strobes while the button is held.

## Interface
- `STABLE_SAMPLES`, default 4: consecutive agreeing samples required to change the debounced level; legal range 1–15.
- `SYNC_STAGES`, default 2: synchroniser flops on `btn_raw`; minimum 2.
- `REPEAT_DELAY`, default 2: repeat-tick edges while held before auto-repeat starts; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  1  asynchronous raw button; 1 = pressed.
- `sample_tick`  in  1  divider debounce square wave; each rising edge is one sample point.
- `repeat_tick`  in  1  divider fast square wave; each rising edge is one repeat point. Ignored when auto-repeat is compiled out.
- `btn_level`  out  1  debounced button level.
- `press_pulse`  out  1  one-cycle strobe on each press, or on each repeat.
- `release_pulse`  out  1  one-cycle strobe on each debounced release.

## Operation
- `btn_raw` passes through a `SYNC_STAGES`-deep flop chain to give `btn_sync`.
- Sample strobe: `sample_tick & ~sample_tick_d`. `sample_tick_d` resets to 1, so a tick that is already high at reset release produces no strobe.
- FSM states:
  - RELEASED → PRESS_PEND when a strobe sees `btn_sync`=1.
  - PRESS_PEND → PRESSED when the stable count reaches `STABLE_SAMPLES`; → RELEASED when a strobe sees 0.
  - PRESSED → REL_PEND when a strobe sees 0.
  - REL_PEND → RELEASED when the count reaches `STABLE_SAMPLES`; → PRESSED when a strobe sees 1.
- `STABLE_SAMPLES`=1 means the level flips on the first disagreeing strobe.
- Stable counter: width `$clog2(STABLE_SAMPLES+1)`. Increments on each strobe that disagrees with `btn_level`. Clears on an agreeing strobe and on every level change. It never wraps.
- `btn_level` is 1 in PRESSED and REL_PEND, 0 otherwise.
- `press_pulse` is high exactly in the first cycle `btn_level` reads 1. `release_pulse` is high exactly in the first cycle `btn_level` reads 0.
- Between strobes, `btn_sync` is ignored.

## Timing
- Reset values: all outputs 0, FSM RELEASED, counters 0, sync chain 0.
- Press latency from `btn_raw` rising to `btn_level`/`press_pulse`:
  - `SYNC_STAGES` cycles
  - plus the wait to the next strobe
  - plus (`STABLE_SAMPLES`−1) tick periods
  - plus 1 cycle.
- Release latency is symmetric.
- Pulses are never held longer than 1 cycle. `press_pulse` and `release_pulse` are never high together.
- `rst` asserted mid-operation returns to reset values on the next edge, with no pulse emitted.

## Configuration
- Macro: `BUTTON_DEBOUNCER_AUTOREPEAT_EN`.
- Defined:
  - While in PRESSED, a repeat counter increments on each `repeat_tick` rising edge (its edge register also resets to 1). It saturates at `REPEAT_DELAY`.
  - Each repeat edge after saturation asserts `press_pulse` for 1 cycle.
  - The counter clears on leaving PRESSED.
  - A repeat edge in the same cycle as the press transition is ignored; only one pulse is emitted.
  - A repeat edge in REL_PEND emits nothing.
- Undefined: repeat logic is absent, `repeat_tick` is unused, and `press_pulse` fires once per debounced press only.

## Structure
- Shared package `pop_timing_pkg`:
  - enum type `debounce_state_t` {RELEASED, PRESS_PEND, PRESSED, REL_PEND}
  - default constants `DEBOUNCE_STABLE_SAMPLES`=4, `DEBOUNCE_REPEAT_DELAY`=2
- One sub-module, `tick_edge_detect`: a registered rising-edge strobe with reset value 1. It is instantiated for `sample_tick` and, when the macro is defined, for `repeat_tick`.

## Test plan
All scenarios use `STABLE_SAMPLES`=4 and a `sample_tick` period of 256 cycles.
- Clean press: `btn_raw` goes 1 and is held for 2000 cycles → `btn_level` rises about 3×256 + 2–256 + 3 cycles later, and `press_pulse` is high exactly 1 cycle.
- Bounce: `btn_raw` toggles every 100 cycles for 1500 cycles, then settles at 1 → no output until 4 consecutive strobes read 1, then exactly one `press_pulse`.
- Glitch rejection: `btn_raw` is high for 3 strobes then low on the 4th → `btn_level` stays 0 and no pulses occur.
- Release: from pressed, `btn_raw`=0 → after 4 strobes `btn_level`=0 and `release_pulse` is high 1 cycle.
- Reset mid-debounce: `rst` pulsed while in PRESS_PEND with count 3 → all outputs 0, the next press needs 4 fresh strobes, and `sample_tick` high at release gives no strobe.
- Auto-repeat (macro on, `REPEAT_DELAY`=2, `repeat_tick` period 1024) with the button held for 10 000 cycles → initial `press_pulse`, then one pulse per `repeat_tick` edge from the 3rd edge onward, and none after release.
